// File: rtl/refill_arbiter_pkg.sv
// Shared state encodings, requester IDs and AXI read constants for refill_arbiter.
package refill_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

  localparam logic [2:0] ARSIZE_4B    = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [1:0] RRESP_OKAY   = 2'b00;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_IC) ? REQ_DC : REQ_IC;
  endfunction

endpackage

// File: rtl/refill_arbiter_if.sv
// AXI4 read-only address/data channels between the refill arbiter and the interconnect.
interface refill_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport slave (
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );
endinterface

// File: rtl/refill_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_arb2
  import refill_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output req_id_t    grant,
  output logic       grant_vld
);

  always_comb begin
    grant_vld = |req;
    grant     = REQ_IC;
    if (&req) begin
      grant = other_req(last_grant);
    end else if (req[1]) begin
      grant = REQ_DC;
    end
  end

endmodule

// File: rtl/refill_arbiter.sv
// Shares one AXI4 read port between icache and dcache refills: one BEATS-beat INCR burst per request, ARVALID one cycle after IDLE sees a pending request.
// Honours ARREADY/RVALID stalls; optional grant/wait counters under REFILL_ARB_STATS_EN.
module refill_arbiter
  import refill_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ic_start,
  input  logic [ADDR_W-1:0]        ic_addr,
  output logic                     ic_busy,
  output logic                     ic_done,
  output logic [DATA_W-1:0]        ic_data,
  output logic [$clog2(BEATS)-1:0] ic_word,
  output logic                     ic_data_valid,
  output logic                     ic_err,
  input  logic                     dc_start,
  input  logic [ADDR_W-1:0]        dc_addr,
  output logic                     dc_busy,
  output logic                     dc_done,
  output logic [DATA_W-1:0]        dc_data,
  output logic [$clog2(BEATS)-1:0] dc_word,
  output logic                     dc_data_valid,
  output logic                     dc_err,
  refill_arbiter_if.master         m
`ifdef REFILL_ARB_STATS_EN
  ,
  output logic [31:0]              stat_ic_grants,
  output logic [31:0]              stat_dc_grants,
  output logic [31:0]              stat_wait_cycles
`endif
);

  localparam int                 BEAT_W    = $clog2(BEATS);
  localparam logic [ADDR_W-1:0]  LINE_MASK = ADDR_W'((BEATS * (DATA_W / 8)) - 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t            state, state_nxt;
  logic              pend_ic, pend_dc;
  logic [ADDR_W-1:0] addr_ic, addr_dc;
  req_id_t           owner, last_grant, grant;
  logic              grant_vld;
  logic [BEAT_W-1:0] beat;
  logic              err;
  logic              arvalid_q, rready_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              ar_hs, r_hs, last_hs, beat_err;

  assign ar_hs    = arvalid_q && m.m_arready;
  assign r_hs     = m.m_rvalid && rready_q;
  assign last_hs  = r_hs && (beat == LAST_BEAT);
  // Completion is counted by beats; a misplaced RLAST is only reported as an error.
  assign beat_err = (m.m_rresp != RRESP_OKAY) || (m.m_rlast != (beat == LAST_BEAT));

  assign m.m_araddr  = araddr_q;
  assign m.m_arlen   = 8'(BEATS - 1);
  assign m.m_arsize  = ARSIZE_4B;
  assign m.m_arburst = ARBURST_INCR;
  assign m.m_arvalid = arvalid_q;
  assign m.m_rready  = rready_q;

  // Busy covers the done cycle: the pending flag clears on the same edge that raises done.
  assign ic_busy = pend_ic || ic_done;
  assign dc_busy = pend_dc || dc_done;

  rr_arb2 u_rr_arb2 (
    .req        ({pend_dc, pend_ic}),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_vld  (grant_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_vld) state_nxt = ST_ADDR;
      ST_ADDR: if (ar_hs)     state_nxt = ST_DATA;
      ST_DATA: if (last_hs)   state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_ic <= 1'b0;
      pend_dc <= 1'b0;
      addr_ic <= '0;
      addr_dc <= '0;
    end else begin
      if (ic_start && !pend_ic) begin
        pend_ic <= 1'b1;
        addr_ic <= ic_addr & ~LINE_MASK;
      end else if (state == ST_DONE && owner == REQ_IC) begin
        pend_ic <= 1'b0;
      end
      if (dc_start && !pend_dc) begin
        pend_dc <= 1'b1;
        addr_dc <= dc_addr & ~LINE_MASK;
      end else if (state == ST_DONE && owner == REQ_DC) begin
        pend_dc <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner         <= REQ_IC;
      last_grant    <= REQ_DC;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      beat          <= '0;
      err           <= 1'b0;
      ic_data       <= '0;
      ic_word       <= '0;
      ic_data_valid <= 1'b0;
      ic_done       <= 1'b0;
      ic_err        <= 1'b0;
      dc_data       <= '0;
      dc_word       <= '0;
      dc_data_valid <= 1'b0;
      dc_done       <= 1'b0;
      dc_err        <= 1'b0;
    end else begin
      ic_data_valid <= 1'b0;
      dc_data_valid <= 1'b0;
      ic_done       <= 1'b0;
      dc_done       <= 1'b0;
      ic_err        <= 1'b0;
      dc_err        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            owner     <= grant;
            araddr_q  <= (grant == REQ_IC) ? addr_ic : addr_dc;
            arvalid_q <= 1'b1;
            err       <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat      <= '0;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            beat <= beat + 1'b1;
            err  <= err | beat_err;
            if (owner == REQ_IC) begin
              ic_data       <= m.m_rdata;
              ic_word       <= beat;
              ic_data_valid <= 1'b1;
            end else begin
              dc_data       <= m.m_rdata;
              dc_word       <= beat;
              dc_data_valid <= 1'b1;
            end
            if (beat == LAST_BEAT) rready_q <= 1'b0;
          end
        end
        ST_DONE: begin
          last_grant <= owner;
          if (owner == REQ_IC) begin
            ic_done <= 1'b1;
            ic_err  <= err;
          end else begin
            dc_done <= 1'b1;
            dc_err  <= err;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REFILL_ARB_STATS_EN
  logic active, wait_inc;
  assign active   = (state != ST_IDLE);
  assign wait_inc = (pend_ic && !(active && owner == REQ_IC)) ||
                    (pend_dc && !(active && owner == REQ_DC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ic_grants   <= '0;
      stat_dc_grants   <= '0;
      stat_wait_cycles <= '0;
    end else begin
      if (state == ST_IDLE && grant_vld && grant == REQ_IC) stat_ic_grants <= stat_ic_grants + 32'd1;
      if (state == ST_IDLE && grant_vld && grant == REQ_DC) stat_dc_grants <= stat_dc_grants + 32'd1;
      if (wait_inc) stat_wait_cycles <= stat_wait_cycles + 32'd1;
    end
  end
`endif

endmodule
